// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard hazard unit.
//   - decode opcode constants (NOP, ADD, INC)
//   - src1_used(): whether an opcode reads its second source operand
//   - MAX_PEND_DEFAULT: default outstanding-write limit per register
package scoreboard_pkg;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] INC = 3'b011;

    localparam int unsigned MAX_PEND_DEFAULT = 3;

    // NOP reads nothing and INC only reads src0.
    function automatic logic src1_used(input logic [2:0] opcode);
        return (opcode != NOP) && (opcode != INC);
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle between the pipeline and the register scoreboard.
//   master : pipeline side, drives decode and writeback, observes stall/status
//   slave  : scoreboard side
// Signals:
//   id_valid, id_src0, id_src1, id_src1_used, id_dst, id_dst_write -> decode request
//   id_stall                                                        <- hold decode
//   wb_valid, wb_dst                                                -> writeback retire
//   busy_mask, wb_err                                               <- scoreboard status
interface reg_scoreboard_if #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned REG_W    = $clog2(NUM_REGS)
);

    logic                id_valid;
    logic [REG_W-1:0]    id_src0;
    logic [REG_W-1:0]    id_src1;
    logic                id_src1_used;
    logic [REG_W-1:0]    id_dst;
    logic                id_dst_write;
    logic                id_stall;
    logic                wb_valid;
    logic [REG_W-1:0]    wb_dst;
    logic [NUM_REGS-1:0] busy_mask;
    logic                wb_err;

    modport master (
        output id_valid, id_src0, id_src1, id_src1_used, id_dst, id_dst_write,
        output wb_valid, wb_dst,
        input  id_stall, busy_mask, wb_err
    );

    modport slave (
        input  id_valid, id_src0, id_src1, id_src1_used, id_dst, id_dst_write,
        input  wb_valid, wb_dst,
        output id_stall, busy_mask, wb_err
    );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: pending-write counter for one architectural register.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_inc          : a write to this register issued this cycle
//   i_dec          : a write to this register retired this cycle
//   o_cnt          : current pending-write count
//   o_busy_d       : count after this cycle's update is nonzero
//   o_underflow    : retire seen with nothing pending (count held at 0)
module sb_counter #(
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned CNT_W    = $clog2(MAX_PEND + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy_d,
    output logic             o_underflow
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_PEND);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_underflow;

    always_comb begin
        w_cnt_d     = r_cnt;
        w_underflow = 1'b0;
        unique case ({i_inc, i_dec})
            2'b10: begin
                // Decode's WAW check keeps this from firing at the limit; the
                // guard only stops a wrap if that check is ever bypassed.
                if (r_cnt != CntMax) begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            2'b01: begin
                if (r_cnt == '0) begin
                    w_underflow = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                // Idle, or issue and retire cancel each other out.
                w_cnt_d = r_cnt;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_busy_d    = (w_cnt_d != '0);
    assign o_underflow = w_underflow & ~i_reset;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write scoreboard beside decode.
// Counts outstanding writes per architectural register and stalls decode while
// a source operand (or a destination at its outstanding-write limit) is busy.
// Ports:
//   i_clk   : rising-edge clock
//   i_reset : synchronous, active-high reset; forces id_stall high
//   sb      : reg_scoreboard_if.slave decode/writeback bundle
// Configuration:
//   REG_SCOREBOARD_WB_BYPASS_EN : when defined, a source whose only pending write
//   is retiring this cycle does not stall (register file forwards wdata).
module reg_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned REG_W    = $clog2(NUM_REGS),
    parameter int unsigned MAX_PEND = MAX_PEND_DEFAULT,
    parameter int unsigned CNT_W    = $clog2(MAX_PEND + 1)
) (
    input  logic           i_clk,
    input  logic           i_reset,
    reg_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_busy_d;
    logic [NUM_REGS-1:0] w_underflow;

    logic w_h0;
    logic w_h1;
    logic w_hw;
    logic w_stall;
    logic w_issue;

    logic [NUM_REGS-1:0] r_busy_mask;
    logic                r_wb_err;

    // Source busy test, optionally forgiving the last pending write retiring now.
    function automatic logic src_hazard(input logic [CNT_W-1:0] cnt,
                                        input logic [REG_W-1:0] src);
        logic hz;
        hz = (cnt != '0);
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
        if (sb.wb_valid && (sb.wb_dst == src) && (cnt == CntOne)) begin
            hz = 1'b0;
        end
`else
        if (src == sb.wb_dst && cnt == CntOne && 1'b0) begin
            hz = 1'b0;
        end
`endif
        return hz;
    endfunction

    always_comb begin
        w_h0    = src_hazard(w_cnt[sb.id_src0], sb.id_src0);
        w_h1    = sb.id_src1_used & src_hazard(w_cnt[sb.id_src1], sb.id_src1);
        w_hw    = sb.id_dst_write & (w_cnt[sb.id_dst] == CntMax);
        w_stall = i_reset | (sb.id_valid & (w_h0 | w_h1 | w_hw));
        w_issue = sb.id_valid & ~w_stall;
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc[i] = w_issue & sb.id_dst_write & (sb.id_dst == REG_W'(i));
            w_dec[i] = sb.wb_valid & (sb.wb_dst == REG_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(
            .MAX_PEND (MAX_PEND),
            .CNT_W    (CNT_W)
        ) u_cnt (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_inc       (w_inc[g]),
            .i_dec       (w_dec[g]),
            .o_cnt       (w_cnt[g]),
            .o_busy_d    (w_busy_d[g]),
            .o_underflow (w_underflow[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy_mask <= '0;
            r_wb_err    <= 1'b0;
        end else begin
            r_busy_mask <= w_busy_d;
            r_wb_err    <= r_wb_err | (|w_underflow);
        end
    end

    assign sb.id_stall  = w_stall;
    assign sb.busy_mask = r_busy_mask;
    assign sb.wb_err    = r_wb_err;

endmodule
